key_event_decoder: RTL and testbench

Consumes the clean, debounced key level produced by the team's key debouncer and converts it into single-cycle event pulses: press, release, short press, long press and auto-repeat. It sits between the debouncer and the control FSMs, such as menu navigation and value increment. Downstream logic reacts to one-cycle strobes instead of polling levels and running its own timers.

---
 rtl/key_event_decoder.sv | 120 ++++++++++++
 tb/tb_key_event_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle press, release, short,
// long and auto-repeat strobes using a single hold counter.
module key_event_decoder #(
   parameter int unsigned LONG_COUNT   = 100_000_000,
   parameter int unsigned REPEAT_COUNT = 20_000_000,
   parameter bit          REPEAT_EN    = 1'b1,
   parameter int unsigned CNT_W        = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic key_held
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_COUNT - 1);
   localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_COUNT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (key_level) begin
               state_d = PRESS;
               press_d = 1'b1;
            end
         end
         PRESS: begin
            // release takes priority over reaching the long threshold
            if (!key_level) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (cnt_q == LONG_M1) begin
               state_d = LONG;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (!key_level) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (!REPEAT_EN) begin
               cnt_d = '0;
            end else if (cnt_q == REP_M1) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d != IDLE);
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign key_held      = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: two decoders (repeat on / off) share key and reset;
// expected strobes are derived from hold time and compared at negedge.
module tb_key_event_decoder;

   localparam int L = 10;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key = 1'b0;

   logic a_pr, a_rl, a_sh, a_lg, a_rp, a_hd;
   logic b_pr, b_rl, b_sh, b_lg, b_rp, b_hd;

   key_event_decoder #(
      .LONG_COUNT(L), .REPEAT_COUNT(R), .REPEAT_EN(1'b1), .CNT_W(8)
   ) dut_a (
      .clk(clk), .rst(rst), .key_level(key),
      .press_pulse(a_pr), .release_pulse(a_rl), .short_pulse(a_sh),
      .long_pulse(a_lg), .repeat_pulse(a_rp), .key_held(a_hd)
   );

   key_event_decoder #(
      .LONG_COUNT(L), .REPEAT_COUNT(R), .REPEAT_EN(1'b0), .CNT_W(8)
   ) dut_b (
      .clk(clk), .rst(rst), .key_level(key),
      .press_pulse(b_pr), .release_pulse(b_rl), .short_pulse(b_sh),
      .long_pulse(b_lg), .repeat_pulse(b_rp), .key_held(b_hd)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   logic [11:0] exp_q[$];
   string tag_q[$];

   task automatic check(input string tag, input logic [11:0] obs,
                        input logic [11:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (pr rl sh lg rp hd | en=0 copy)",
                  tag, obs, exp);
      end
   endtask

   // Reference: tracks edges since the press edge (h) per copy.
   typedef struct {
      bit held;
      int h;
   } ref_t;
   ref_t ra = '{0, 0};
   ref_t rb = '{0, 0};

   function automatic logic [5:0] ref_step(inout ref_t r, input bit en,
                                           input bit k, input bit rs);
      logic [5:0] o;
      o = '0;
      if (rs) begin
         r.held = 0;
         r.h    = 0;
      end else if (!r.held) begin
         if (k) begin
            r.held = 1;
            r.h    = 0;
            o[5]   = 1'b1;
         end
      end else begin
         r.h++;
         if (!k) begin
            r.held = 0;
            o[4]   = 1'b1;
            o[3]   = (r.h <= L);
         end else begin
            o[2] = (r.h == L);
            o[1] = en && (r.h > L) && ((r.h - L) % R == 0);
         end
      end
      o[0] = r.held;
      return o;
   endfunction

   task automatic step(input bit k, input bit rs, input string tag);
      logic [5:0] ea, eb;
      key = k;
      rst = rs;
      @(posedge clk);
      ea = ref_step(ra, 1'b1, k, rs);
      eb = ref_step(rb, 1'b0, k, rs);
      exp_q.push_back({ea, eb});
      tag_q.push_back(tag);
      #2;
   endtask

   task automatic hold(input bit k, input int n, input string tag);
      for (int i = 0; i < n; i++) step(k, 1'b0, tag);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         check(tag_q.pop_front(),
               {a_pr, a_rl, a_sh, a_lg, a_rp, a_hd,
                b_pr, b_rl, b_sh, b_lg, b_rp, b_hd},
               exp_q.pop_front());
      end
   end

   initial begin
      step(1'b1, 1'b1, "rst");
      step(1'b1, 1'b1, "rst");
      step(1'b1, 1'b1, "rst");
      hold(1'b1, 1, "rst_rel_press");
      hold(1'b0, 3, "rst_rel_off");

      hold(1'b1, 5, "short_on");
      hold(1'b0, 3, "short_off");

      hold(1'b1, 25, "long_rep");
      hold(1'b0, 3, "long_off");

      hold(1'b1, 10, "race_on");
      hold(1'b0, 1, "race_off");
      hold(1'b1, 3, "repress");
      hold(1'b0, 2, "repress_off");

      hold(1'b1, 30, "hold30");
      hold(1'b0, 2, "hold30_off");

      hold(1'b1, 12, "mid_hold");
      step(1'b1, 1'b1, "mid_rst");
      step(1'b1, 1'b1, "mid_rst");
      hold(1'b1, 14, "after_rst");
      hold(1'b0, 2, "after_rst_off");

      for (int i = 0; i < 40; i++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)), "rand");
      end
      hold(1'b0, 3, "tail");

      @(negedge clk);
      #1;
      check("drain", 12'(exp_q.size()), 12'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
